// File: rtl/dma_pkg.sv
// dma_pkg
// Shared definitions for the DMA stream sender: controller state encoding,
// default data/length widths, output buffer sizing and a helper that decides
// whether another FIFO pop still fits in the output buffer.
package dma_pkg;

  localparam int DMA_DATA_WIDTH = 32;
  localparam int DMA_LEN_WIDTH  = 16;

  // Output buffer geometry: 4 entries, 2-bit pointers, 3-bit count (0..4).
  localparam int BUF_DEPTH = 4;
  localparam int BUF_PTR_W = 2;
  localparam int BUF_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } dma_state_e;

  // A pop may be issued only if every beat already buffered or still in
  // flight from the FIFO, plus the new one, fits in the buffer.
  function automatic logic buf_has_room(input logic [BUF_CNT_W-1:0] occ,
                                        input logic inflight);
    logic [BUF_CNT_W:0] total;
    total = {1'b0, occ} + {{BUF_CNT_W{1'b0}}, inflight};
    return total < (BUF_CNT_W+1)'(BUF_DEPTH);
  endfunction

endpackage

// File: rtl/dma_stream_sender_if.sv
// dma_stream_sender_if
// Groups the configuration, upstream FIFO and downstream AXI-stream signals
// of the DMA stream sender.
//   cfg_start/cfg_len             : one-cycle start request and beat count
//   fifo_empty/fifo_read_en       : upstream FIFO empty flag and pop request
//   fifo_valid/fifo_data          : FIFO read data, one cycle after a pop
//   m_axis_tvalid/tdata/tlast/tready : outgoing stream
//   busy/done                     : transfer status
// Modport master is the sender side, slave is the environment side.
interface dma_stream_sender_if
  import dma_pkg::*;
#(
  parameter int DATA_WIDTH = DMA_DATA_WIDTH,
  parameter int LEN_WIDTH  = DMA_LEN_WIDTH
) ();

  logic                  cfg_start;
  logic [LEN_WIDTH-1:0]  cfg_len;
  logic                  fifo_empty;
  logic                  fifo_read_en;
  logic                  fifo_valid;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  m_axis_tvalid;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tlast;
  logic                  m_axis_tready;
  logic                  busy;
  logic                  done;

  modport master (
    input  cfg_start, cfg_len, fifo_empty, fifo_valid, fifo_data, m_axis_tready,
    output fifo_read_en, m_axis_tvalid, m_axis_tdata, m_axis_tlast, busy, done
  );

  modport slave (
    output cfg_start, cfg_len, fifo_empty, fifo_valid, fifo_data, m_axis_tready,
    input  fifo_read_en, m_axis_tvalid, m_axis_tdata, m_axis_tlast, busy, done
  );

endinterface

// File: rtl/stream_out_buf.sv
// stream_out_buf
// 4-entry in-order buffer between the FIFO read port and the stream output.
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   push       : write push_data at the tail
//   pop        : drop the head entry
//   head       : current head entry (zero after reset)
//   count      : number of valid entries (0..4)
// A simultaneous push and pop leaves count unchanged; a push into a full
// buffer is only taken when the head is popped in the same cycle.
module stream_out_buf
  import dma_pkg::*;
#(
  parameter int DATA_WIDTH = DMA_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [BUF_CNT_W-1:0]  count
);

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
  logic [BUF_PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [BUF_PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [BUF_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  do_push, do_pop;

  always_comb begin
    do_pop   = pop && (cnt_q != '0);
    do_push  = push && ((cnt_q != BUF_CNT_W'(BUF_DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + BUF_PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + BUF_PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + BUF_CNT_W'(1);
      2'b01:   cnt_d = cnt_q - BUF_CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/dma_stream_sender.sv
// dma_stream_sender
// Moves cfg_len beats from an upstream FIFO onto an AXI-stream output.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : dma_stream_sender_if.master (config, FIFO read port, stream
//              output, busy/done status)
// IDLE accepts cfg_start; SEND pops the FIFO and streams beats out of a
// 4-entry buffer; DONE lasts one cycle and pulses done. A zero-length start
// goes straight to DONE. The FIFO pop is registered and is decided one
// cycle ahead, so the first beat appears 3 cycles after cfg_start.
module dma_stream_sender
  import dma_pkg::*;
#(
  parameter int DATA_WIDTH = DMA_DATA_WIDTH,
  parameter int LEN_WIDTH  = DMA_LEN_WIDTH
) (
  input logic               clk,
  input logic               rst,
  dma_stream_sender_if.master bus
);

  dma_state_e            state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  issued_q, issued_d;
  logic [LEN_WIDTH-1:0]  sent_q, sent_d;
  logic                  inflight_q, inflight_d;
  logic                  rd_en_q, rd_en_d;

  logic [BUF_CNT_W-1:0]  occ;
  logic [BUF_CNT_W-1:0]  occ_next;
  logic [DATA_WIDTH-1:0] head;
  logic                  buf_push, buf_pop;
  logic                  grant, tvalid, tlast, beat;

  stream_out_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (buf_push),
    .push_data(bus.fifo_data),
    .pop      (buf_pop),
    .head     (head),
    .count    (occ)
  );

  always_comb begin
    tvalid   = (occ != '0);
    tlast    = tvalid && (sent_q == (len_q - LEN_WIDTH'(1)));
    beat     = tvalid && bus.m_axis_tready;
    // A registered pop only counts when the FIFO actually had data for it.
    grant    = rd_en_q && !bus.fifo_empty;
    buf_push = bus.fifo_valid && inflight_q;
    buf_pop  = beat;

    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    sent_d     = sent_q;
    inflight_d = grant;

    case (state_q)
      IDLE: begin
        if (bus.cfg_start) begin
          len_d    = bus.cfg_len;
          issued_d = '0;
          sent_d   = '0;
          state_d  = (bus.cfg_len != '0) ? SEND : DONE;
        end
      end
      SEND: begin
        if (grant) begin
          issued_d = issued_q + LEN_WIDTH'(1);
        end
        if (beat) begin
          sent_d = sent_q + LEN_WIDTH'(1);
          if (tlast) begin
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Decide next cycle's pop from next cycle's view of the counters and the
    // buffer, so the registered read enable never overfills the buffer and
    // m_axis_tready only reaches fifo_read_en through a flop.
    occ_next = occ + BUF_CNT_W'(buf_push) - BUF_CNT_W'(buf_pop);
    rd_en_d  = (state_d == SEND) && !bus.fifo_empty && (issued_d < len_d) &&
               buf_has_room(occ_next, inflight_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      inflight_q <= 1'b0;
      rd_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      sent_q     <= sent_d;
      inflight_q <= inflight_d;
      rd_en_q    <= rd_en_d;
    end
  end

  assign bus.fifo_read_en  = rd_en_q;
  assign bus.m_axis_tvalid = tvalid;
  assign bus.m_axis_tdata  = head;
  assign bus.m_axis_tlast  = tlast;
  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = (state_q == DONE);

endmodule

// File: tb/tb_dma_stream_sender.sv
// tb_dma_stream_sender
// Drives dma_stream_sender through an interface instance with a behavioural
// upstream FIFO. Expected beats are queued when the FIFO is loaded and are
// popped and compared as the DUT hands them over on the stream.
module tb_dma_stream_sender;

  localparam int DW = 32;
  localparam int LW = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  beat_t exp_q[$];

  logic [DW-1:0] fifo_store [256];
  int   fifo_wr    = 0;
  int   fifo_rd    = 0;
  int   pop_count  = 0;
  logic fifo_flush = 1'b0;
  logic spurious   = 1'b0;

  dma_stream_sender_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut_if ();

  dma_stream_sender #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(dut_if.master)
  );

  always #5 clk = ~clk;

  assign dut_if.fifo_empty = (fifo_rd == fifo_wr);

  // Upstream FIFO: a pop granted while non-empty returns data one cycle later.
  always @(posedge clk) begin
    if (fifo_flush) begin
      fifo_rd           <= fifo_wr;
      dut_if.fifo_valid <= 1'b0;
    end else if (dut_if.fifo_read_en && !dut_if.fifo_empty) begin
      dut_if.fifo_data  <= fifo_store[fifo_rd % 256];
      dut_if.fifo_valid <= 1'b1;
      fifo_rd           <= fifo_rd + 1;
      pop_count         <= pop_count + 1;
    end else begin
      dut_if.fifo_data  <= $urandom;
      dut_if.fifo_valid <= spurious;
    end
  end

  task automatic load_fifo(input int n, input logic [DW-1:0] base, input int len, input bit push_exp);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      fifo_store[fifo_wr % 256] = base + DW'(i);
      fifo_wr++;
      if (push_exp) begin
        b.data = base + DW'(i);
        b.last = (i == len - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if ({dut_if.fifo_read_en, dut_if.m_axis_tvalid, dut_if.m_axis_tdata, dut_if.m_axis_tlast, dut_if.busy, dut_if.done} !== '0) begin
      n_err++;
      $display("[TB] FAIL reset_outputs got rd=%b v=%b d=%h l=%b busy=%b done=%b required all 0",
               dut_if.fifo_read_en, dut_if.m_axis_tvalid, dut_if.m_axis_tdata, dut_if.m_axis_tlast, dut_if.busy, dut_if.done);
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({dut_if.busy, dut_if.done} !== 2'b00) begin
      n_err++;
      $display("[TB] FAIL reset_release_idle got busy=%b done=%b required 0/0", dut_if.busy, dut_if.done);
    end
  endtask

  task automatic test_basic_len4();
    beat_t eb;
    int pops0, first_valid, done_cyc, last_cyc;
    pops0 = pop_count; first_valid = -1; done_cyc = -1; last_cyc = -1;
    load_fifo(4, 32'hA0, 4, 1'b1);
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      dut_if.cfg_start = (cyc == 0); dut_if.cfg_len = 16'd4; dut_if.m_axis_tready = 1'b1;
      if (dut_if.m_axis_tvalid && first_valid < 0) first_valid = cyc;
      if (dut_if.done && done_cyc < 0) done_cyc = cyc;
      if (dut_if.m_axis_tvalid && dut_if.m_axis_tready) begin
        n_vec++;
        if (dut_if.m_axis_tlast) last_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_err++; $display("[TB] FAIL basic_beat got data=%h required no beat", dut_if.m_axis_tdata);
        end else begin
          eb = exp_q.pop_front();
          if ({dut_if.m_axis_tdata, dut_if.m_axis_tlast} !== {eb.data, eb.last}) begin
            n_err++; $display("[TB] FAIL basic_beat got %h/%b required %h/%b", dut_if.m_axis_tdata, dut_if.m_axis_tlast, eb.data, eb.last);
          end
        end
      end
    end
    n_vec++;
    if (first_valid !== 3) begin n_err++; $display("[TB] FAIL basic_latency got %0d required 3", first_valid); end
    n_vec++;
    if (last_cyc !== first_valid + 3) begin n_err++; $display("[TB] FAIL basic_consecutive got last at %0d required %0d", last_cyc, first_valid + 3); end
    n_vec++;
    if (done_cyc !== last_cyc + 1) begin n_err++; $display("[TB] FAIL basic_done_pulse got %0d required %0d", done_cyc, last_cyc + 1); end
    n_vec++;
    if (exp_q.size() !== 0 || pop_count - pops0 !== 4) begin
      n_err++; $display("[TB] FAIL basic_complete got left=%0d pops=%0d required 0/4", exp_q.size(), pop_count - pops0);
    end
  endtask

  task automatic test_toggle_ready();
    beat_t eb;
    int pops0;
    bit stalled, done_seen;
    logic [DW-1:0] hold_d;
    logic hold_l;
    pops0 = pop_count; stalled = 0; done_seen = 0; hold_d = '0; hold_l = 1'b0;
    load_fifo(8, 32'h10, 8, 1'b1);
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      dut_if.cfg_start = (cyc == 0); dut_if.cfg_len = 16'd8; dut_if.m_axis_tready = (cyc % 2 == 0);
      if (stalled) begin
        n_vec++;
        if ({dut_if.m_axis_tvalid, dut_if.m_axis_tdata, dut_if.m_axis_tlast} !== {1'b1, hold_d, hold_l}) begin
          n_err++; $display("[TB] FAIL toggle_stall_hold got %b/%h/%b required 1/%h/%b",
                            dut_if.m_axis_tvalid, dut_if.m_axis_tdata, dut_if.m_axis_tlast, hold_d, hold_l);
        end
      end
      if (dut_if.m_axis_tvalid && dut_if.m_axis_tready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("[TB] FAIL toggle_beat got data=%h required no beat", dut_if.m_axis_tdata);
        end else begin
          eb = exp_q.pop_front();
          if ({dut_if.m_axis_tdata, dut_if.m_axis_tlast} !== {eb.data, eb.last}) begin
            n_err++; $display("[TB] FAIL toggle_beat got %h/%b required %h/%b", dut_if.m_axis_tdata, dut_if.m_axis_tlast, eb.data, eb.last);
          end
        end
      end
      if (dut_if.done) done_seen = 1;
      stalled = dut_if.m_axis_tvalid && !dut_if.m_axis_tready;
      hold_d  = dut_if.m_axis_tdata;
      hold_l  = dut_if.m_axis_tlast;
    end
    n_vec++;
    if (!done_seen || exp_q.size() !== 0) begin
      n_err++; $display("[TB] FAIL toggle_complete got done=%b left=%0d required 1/0", done_seen, exp_q.size());
    end
    n_vec++;
    if (pop_count - pops0 !== 8) begin n_err++; $display("[TB] FAIL toggle_pops got %0d required 8", pop_count - pops0); end
  endtask

  task automatic test_empty_then_fill();
    beat_t eb;
    int pops0, early_pop, empty_pop;
    bit done_seen;
    pops0 = pop_count; early_pop = 0; empty_pop = 0; done_seen = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      dut_if.cfg_start = (cyc == 0); dut_if.cfg_len = 16'd3; dut_if.m_axis_tready = 1'b1;
      if (cyc == 5) load_fifo(3, 32'hC0, 3, 1'b1);
      if (cyc <= 5 && dut_if.fifo_read_en) early_pop++;
      if (dut_if.fifo_read_en && dut_if.fifo_empty) empty_pop++;
      if (dut_if.m_axis_tvalid && dut_if.m_axis_tready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("[TB] FAIL empty_beat got data=%h required no beat", dut_if.m_axis_tdata);
        end else begin
          eb = exp_q.pop_front();
          if ({dut_if.m_axis_tdata, dut_if.m_axis_tlast} !== {eb.data, eb.last}) begin
            n_err++; $display("[TB] FAIL empty_beat got %h/%b required %h/%b", dut_if.m_axis_tdata, dut_if.m_axis_tlast, eb.data, eb.last);
          end
        end
      end
      if (dut_if.done) done_seen = 1;
    end
    n_vec++;
    if (early_pop !== 0 || empty_pop !== 0) begin
      n_err++; $display("[TB] FAIL empty_no_pop got early=%0d while_empty=%0d required 0/0", early_pop, empty_pop);
    end
    n_vec++;
    if (!done_seen || exp_q.size() !== 0 || pop_count - pops0 !== 3) begin
      n_err++; $display("[TB] FAIL empty_complete got done=%b left=%0d pops=%0d required 1/0/3", done_seen, exp_q.size(), pop_count - pops0);
    end
  endtask

  task automatic test_zero_len();
    int pops0, bad_out;
    pops0 = pop_count; bad_out = 0;
    load_fifo(1, 32'hEE, 0, 1'b0);
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      dut_if.cfg_start = (cyc == 0); dut_if.cfg_len = 16'd0; dut_if.m_axis_tready = 1'b1;
      spurious = (cyc == 3);
      if (dut_if.fifo_read_en || dut_if.m_axis_tvalid) bad_out++;
      if (cyc == 1) begin
        n_vec++;
        if ({dut_if.done, dut_if.busy} !== 2'b11) begin
          n_err++; $display("[TB] FAIL zero_done got done=%b busy=%b required 1/1", dut_if.done, dut_if.busy);
        end
      end
      if (cyc == 2) begin
        n_vec++;
        if ({dut_if.done, dut_if.busy} !== 2'b00) begin
          n_err++; $display("[TB] FAIL zero_idle got done=%b busy=%b required 0/0", dut_if.done, dut_if.busy);
        end
      end
    end
    n_vec++;
    if (bad_out !== 0 || pop_count - pops0 !== 0) begin
      n_err++; $display("[TB] FAIL zero_no_activity got active_cycles=%0d pops=%0d required 0/0", bad_out, pop_count - pops0);
    end
    fifo_flush = 1'b1;
    @(negedge clk);
    fifo_flush = 1'b0;
  endtask

  task automatic test_stall();
    beat_t eb;
    int pops0, stall_pops;
    bit done_seen;
    pops0 = pop_count; stall_pops = 0; done_seen = 0;
    load_fifo(6, 32'hB0, 6, 1'b1);
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      dut_if.cfg_start = (cyc == 0); dut_if.cfg_len = 16'd6; dut_if.m_axis_tready = (cyc >= 10);
      if (cyc == 9) begin
        stall_pops = pop_count - pops0;
        n_vec++;
        if (stall_pops > 4 || stall_pops < 1) begin
          n_err++; $display("[TB] FAIL stall_outstanding got %0d pops required 1..4", stall_pops);
        end
        n_vec++;
        if ({dut_if.m_axis_tvalid, dut_if.m_axis_tdata, dut_if.m_axis_tlast} !== {1'b1, 32'hB0, 1'b0}) begin
          n_err++; $display("[TB] FAIL stall_head got %b/%h/%b required 1/000000b0/0",
                            dut_if.m_axis_tvalid, dut_if.m_axis_tdata, dut_if.m_axis_tlast);
        end
      end
      if (dut_if.m_axis_tvalid && dut_if.m_axis_tready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("[TB] FAIL stall_beat got data=%h required no beat", dut_if.m_axis_tdata);
        end else begin
          eb = exp_q.pop_front();
          if ({dut_if.m_axis_tdata, dut_if.m_axis_tlast} !== {eb.data, eb.last}) begin
            n_err++; $display("[TB] FAIL stall_beat got %h/%b required %h/%b", dut_if.m_axis_tdata, dut_if.m_axis_tlast, eb.data, eb.last);
          end
        end
      end
      if (dut_if.done) done_seen = 1;
    end
    n_vec++;
    if (!done_seen || exp_q.size() !== 0 || pop_count - pops0 !== 6) begin
      n_err++; $display("[TB] FAIL stall_complete got done=%b lost=%0d pops=%0d required 1/0/6", done_seen, exp_q.size(), pop_count - pops0);
    end
  endtask

  task automatic test_reset_mid();
    beat_t eb;
    int first_valid, done_cyc;
    first_valid = -1; done_cyc = -1;
    load_fifo(5, 32'h50, 5, 1'b1);
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      dut_if.cfg_start = (cyc == 0); dut_if.cfg_len = 16'd5; dut_if.m_axis_tready = 1'b1;
      if (dut_if.m_axis_tvalid && dut_if.m_axis_tready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("[TB] FAIL rstmid_beat got data=%h required no beat", dut_if.m_axis_tdata);
        end else begin
          eb = exp_q.pop_front();
          if ({dut_if.m_axis_tdata, dut_if.m_axis_tlast} !== {eb.data, eb.last}) begin
            n_err++; $display("[TB] FAIL rstmid_beat got %h/%b required %h/%b", dut_if.m_axis_tdata, dut_if.m_axis_tlast, eb.data, eb.last);
          end
        end
      end
    end
    @(negedge clk);
    n_vec++;
    if ({dut_if.m_axis_tvalid, dut_if.m_axis_tdata} !== {1'b1, 32'h51}) begin
      n_err++; $display("[TB] FAIL rstmid_second_beat got %b/%h required 1/00000051", dut_if.m_axis_tvalid, dut_if.m_axis_tdata);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({dut_if.fifo_read_en, dut_if.m_axis_tvalid, dut_if.m_axis_tdata, dut_if.m_axis_tlast, dut_if.busy, dut_if.done} !== '0) begin
      n_err++; $display("[TB] FAIL rstmid_outputs got rd=%b v=%b d=%h l=%b busy=%b done=%b required all 0",
                        dut_if.fifo_read_en, dut_if.m_axis_tvalid, dut_if.m_axis_tdata, dut_if.m_axis_tlast, dut_if.busy, dut_if.done);
    end
    exp_q.delete();
    fifo_flush = 1'b1;
    @(negedge clk);
    fifo_flush = 1'b0;
    load_fifo(2, 32'hD0, 2, 1'b1);
    rst = 1'b0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (cyc != 0) @(negedge clk);
      dut_if.cfg_start = (cyc == 0); dut_if.cfg_len = 16'd2; dut_if.m_axis_tready = 1'b1;
      if (dut_if.m_axis_tvalid && first_valid < 0) first_valid = cyc;
      if (dut_if.done && done_cyc < 0) done_cyc = cyc;
      if (dut_if.m_axis_tvalid && dut_if.m_axis_tready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("[TB] FAIL rstmid_new_beat got data=%h required no beat", dut_if.m_axis_tdata);
        end else begin
          eb = exp_q.pop_front();
          if ({dut_if.m_axis_tdata, dut_if.m_axis_tlast} !== {eb.data, eb.last}) begin
            n_err++; $display("[TB] FAIL rstmid_new_beat got %h/%b required %h/%b", dut_if.m_axis_tdata, dut_if.m_axis_tlast, eb.data, eb.last);
          end
        end
      end
    end
    n_vec++;
    if (first_valid !== 3 || done_cyc !== 5 || exp_q.size() !== 0) begin
      n_err++; $display("[TB] FAIL rstmid_new_transfer got first=%0d done=%0d left=%0d required 3/5/0", first_valid, done_cyc, exp_q.size());
    end
  endtask

  initial begin
    dut_if.cfg_start     = 1'b0;
    dut_if.cfg_len       = '0;
    dut_if.m_axis_tready = 1'b0;
    $display("[TB] starting dma_stream_sender bench");
    test_reset();
    test_basic_len4();
    test_toggle_ready();
    test_empty_then_fill();
    test_zero_len();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dma_stream_sender.md
DMA_STREAM_SENDER -- requirements
Module: dma_stream_sender

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning stream and FIFO data width.
REQ-002 The block SHALL have parameter LEN_WIDTH, default 16, meaning transfer-length counter width.
REQ-003 The block SHALL have port clk  input  1  clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port cfg_start  input  1  one-cycle start request.
REQ-006 The block SHALL have port cfg_len  input  LEN_WIDTH  beat count, sampled on an accepted start.
REQ-007 The block SHALL have port fifo_empty  input  1  upstream FIFO empty flag.
REQ-008 The block SHALL have port fifo_read_en  output  1  FIFO pop request.
REQ-009 The block SHALL have port fifo_valid  input  1  FIFO read data valid, one cycle after a granted pop.
REQ-010 The block SHALL have port fifo_data  input  DATA_WIDTH  FIFO read data.
REQ-011 The block SHALL have port m_axis_tvalid  output  1  stream beat valid.
REQ-012 The block SHALL have port m_axis_tdata  output  DATA_WIDTH  stream beat data.
REQ-013 The block SHALL have port m_axis_tlast  output  1  final beat of the transfer.
REQ-014 The block SHALL have port m_axis_tready  input  1  downstream accept.
REQ-015 The block SHALL have port busy  output  1  transfer in progress.
REQ-016 The block SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-017 States SHALL be IDLE, SEND and DONE.
REQ-018 IDLE->SEND SHALL occur on cfg_start with cfg_len!=0; cfg_len is latched and the issue/sent counters are cleared.
REQ-019 IDLE->DONE SHALL occur on cfg_start with cfg_len==0; no FIFO pop and no beat occur.
REQ-020 cfg_start SHALL be ignored in SEND and DONE.
REQ-021 SEND->DONE SHALL occur in the cycle after the beat with tlast is accepted (tvalid&&tready); DONE->IDLE SHALL occur unconditionally after one cycle.
REQ-022 done SHALL be 1 only in DONE; busy SHALL be 1 in SEND and DONE.
REQ-023 fifo_read_en SHALL be registered and asserted only in SEND when !fifo_empty, issued<len and (buf_occupancy+inflight)<4.
REQ-024 inflight SHALL be 1 in the cycle after a pop and 0 otherwise; fifo_valid with inflight==0 SHALL be ignored.
REQ-025 fifo_data SHALL be written into a 4-entry in-order output buffer when fifo_valid&&inflight.
REQ-026 m_axis_tvalid SHALL equal buffer non-empty; m_axis_tdata SHALL be the buffer head.
REQ-027 tdata/tlast SHALL hold stable while tvalid&&!tready, and tvalid SHALL NOT drop without acceptance.
REQ-028 m_axis_tlast SHALL be 1 exactly when the head beat index equals len-1.
REQ-029 A simultaneous buffer write and head pop SHALL leave occupancy unchanged.
REQ-030 Steady-state throughput SHALL be 1 beat/cycle with FIFO non-empty and tready held 1; first-beat latency from cfg_start SHALL be 3 cycles (pop, data, tvalid).
REQ-031 Counters SHALL be LEN_WIDTH bits; len=2^LEN_WIDTH-1 SHALL complete without wrap.
REQ-032 m_axis_tready SHALL have no combinational path to fifo_read_en.

Reset
REQ-033 rst SHALL force IDLE, clear counters, inflight and the buffer, and drive fifo_read_en, m_axis_tvalid, m_axis_tdata, m_axis_tlast, busy and done to 0, including mid-transfer.
REQ-034 After rst deassertion the block SHALL accept cfg_start on the first clock edge.

Structure
REQ-035 The state encoding, DATA_WIDTH and LEN_WIDTH defaults SHALL live in shared package dma_pkg.
REQ-036 The 4-entry output buffer SHALL be sub-module stream_out_buf (push, pop, head, count).

Verification
REQ-037 The bench SHALL cover: len=4, FIFO preloaded 0xA0..0xA3, tready=1 -> 4 consecutive beats, tlast on 0xA3, done pulse one cycle later.
REQ-038 The bench SHALL cover: len=8, tready toggling 1010... -> data order preserved, tdata stable while stalled, exactly 8 pops.
REQ-039 The bench SHALL cover: len=3 with FIFO empty for 5 cycles then filled -> no pop while empty; 3 beats afterwards.
REQ-040 The bench SHALL cover: len=0 -> no pop, no tvalid, done 1 cycle after start.
REQ-041 The bench SHALL cover: tready=0 for 10 cycles, len=6 -> at most 4 pops outstanding, 0 lost beats after release.
REQ-042 The bench SHALL cover: rst asserted mid-transfer (beat 2 of 5) -> all outputs 0 immediately; a new len=2 transfer then completes normally.
